// File: rtl/eeg_chip_pkg.sv
// Shared constants and types for the CHIP_DAT pad receiver.
`timescale 1ns/1ps
package eeg_chip_pkg;

  localparam int CHIP_DAT_DW = 8;
  localparam int WORD_DW     = 32;
  localparam int PACK        = WORD_DW / CHIP_DAT_DW;
  localparam int CNT_W       = $clog2(PACK) + 1;

  // One queued word: closing flag, number of valid beats, packed payload.
  typedef struct packed {
    logic             lst;
    logic [CNT_W-1:0] cnt;
    logic [WORD_DW-1:0] dat;
  } word_ent_t;

  // The packer is either empty or holding a partially filled word.
  typedef enum logic {
    PK_IDLE,
    PK_FILL
  } pack_state_t;

endpackage

// File: rtl/chip_dat_fifo.sv
// Small synchronous FIFO of packed words between the packer and the core.
// Pointers carry one extra bit so that full and empty can be told apart.
`timescale 1ns/1ps
module chip_dat_fifo
  import eeg_chip_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  word_ent_t push_ent,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output word_ent_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  word_ent_t   mem_q [FIFO_DEPTH];
  word_ent_t   mem_d [FIFO_DEPTH];

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Write the new entry at the tail and advance whichever pointers moved.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_ent;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage and pointers; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/chip_dat_rx.sv
// Chip-side receiver for the CHIP_DAT pad stream: splits command beats into
// a one-entry register and packs data beats LSB-first into queued words.
`timescale 1ns/1ps
module chip_dat_rx
  import eeg_chip_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   chip_dat_vld,
  input  logic                   chip_dat_lst,
  input  logic [CHIP_DAT_DW-1:0] chip_dat_dat,
  input  logic                   chip_dat_cmd,
  output logic                   chip_dat_rdy,
  output logic                   cmd_vld,
  output logic [CHIP_DAT_DW-1:0] cmd_dat,
  input  logic                   cmd_rdy,
  output logic                   word_vld,
  output logic [WORD_DW-1:0]     word_dat,
  output logic                   word_lst,
  output logic [CNT_W-1:0]       word_cnt,
  input  logic                   word_rdy,
  output logic                   err_cmd_mid
);

  pack_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_DW-1:0]     pack_q, pack_d;
  logic [WORD_DW-1:0]     merged;
  logic                   cmd_vld_q, cmd_vld_d;
  logic [CHIP_DAT_DW-1:0] cmd_dat_q, cmd_dat_d;
  logic                   err_q, err_d;
  logic                   run_q, run_d;

  logic      beat_acc, data_acc, cmd_acc;
  logic      push, pop;
  word_ent_t push_ent, head;
  logic      fifo_full, fifo_empty;

  // run_q holds ready low for the first cycle after reset so every output is 0 in reset.
  assign chip_dat_rdy = run_q && !fifo_full && !cmd_vld_q;
  assign beat_acc     = chip_dat_vld && chip_dat_rdy;
  assign data_acc     = beat_acc && !chip_dat_cmd;
  assign cmd_acc      = beat_acc && chip_dat_cmd;

  assign word_vld    = !fifo_empty;
  assign word_dat    = head.dat;
  assign word_lst    = head.lst;
  assign word_cnt    = head.cnt;
  assign pop         = word_vld && word_rdy;
  assign cmd_vld     = cmd_vld_q;
  assign cmd_dat     = cmd_dat_q;
  assign err_cmd_mid = err_q;

  // Packer: drop each data beat into its lane and emit the word when full or on lst.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pack_d   = pack_q;
    push     = 1'b0;
    push_ent = '0;
    merged   = pack_q;
    for (int i = 0; i < PACK; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        merged[i*CHIP_DAT_DW +: CHIP_DAT_DW] = chip_dat_dat;
      end
    end
    if (data_acc) begin
      if (cnt_q == CNT_W'(PACK-1) || chip_dat_lst) begin
        push         = 1'b1;
        push_ent.lst = chip_dat_lst;
        push_ent.cnt = cnt_q + CNT_W'(1);
        push_ent.dat = merged;
        cnt_d        = '0;
        pack_d       = '0;
        state_d      = PK_IDLE;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        pack_d  = merged;
        state_d = PK_FILL;
      end
    end
  end

  // Command register: load on an accepted command beat, release on cmd_rdy,
  // and flag a command that lands while a word is half built.
  always_comb begin
    cmd_vld_d = cmd_vld_q;
    cmd_dat_d = cmd_dat_q;
    err_d     = 1'b0;
    run_d     = 1'b1;
    if (cmd_vld_q && cmd_rdy) begin
      cmd_vld_d = 1'b0;
    end
    if (cmd_acc) begin
      cmd_vld_d = 1'b1;
      cmd_dat_d = chip_dat_dat;
      err_d     = (state_q == PK_FILL);
    end
  end

  // State registers for the packer, the command slot and the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PK_IDLE;
      cnt_q     <= '0;
      pack_q    <= '0;
      cmd_vld_q <= 1'b0;
      cmd_dat_q <= '0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_dat_q <= cmd_dat_d;
      err_q     <= err_d;
      run_q     <= run_d;
    end
  end

  chip_dat_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

endmodule

// File: tb/tb_chip_dat_rx.sv
// Self-checking bench for chip_dat_rx: directed scenarios plus random traffic,
// all compared against a queue-based model of the beat/word/command rules.
`timescale 1ns/1ps
module tb_chip_dat_rx;

  localparam int DW    = 8;
  localparam int WDW   = 32;
  localparam int PACK  = 4;
  localparam int DEPTH = 2;

  logic           clk;
  logic           rst_n;
  logic           chip_dat_vld;
  logic           chip_dat_lst;
  logic [DW-1:0]  chip_dat_dat;
  logic           chip_dat_cmd;
  logic           chip_dat_rdy;
  logic           cmd_vld;
  logic [DW-1:0]  cmd_dat;
  logic           cmd_rdy;
  logic           word_vld;
  logic [WDW-1:0] word_dat;
  logic           word_lst;
  logic [2:0]     word_cnt;
  logic           word_rdy;
  logic           err_cmd_mid;

  chip_dat_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .chip_dat_vld (chip_dat_vld),
    .chip_dat_lst (chip_dat_lst),
    .chip_dat_dat (chip_dat_dat),
    .chip_dat_cmd (chip_dat_cmd),
    .chip_dat_rdy (chip_dat_rdy),
    .cmd_vld      (cmd_vld),
    .cmd_dat      (cmd_dat),
    .cmd_rdy      (cmd_rdy),
    .word_vld     (word_vld),
    .word_dat     (word_dat),
    .word_lst     (word_lst),
    .word_cnt     (word_cnt),
    .word_rdy     (word_rdy),
    .err_cmd_mid  (err_cmd_mid)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: queued words, beats of the open word, command slot.
  typedef struct {
    logic [WDW-1:0] dat;
    logic           lst;
    int             cnt;
  } mword_t;

  mword_t        m_fifo[$];
  logic [DW-1:0] m_lanes[$];
  logic          m_cmd_pend;
  logic [DW-1:0] m_cmd_dat;
  logic          m_err;
  logic          m_run;
  logic          last_acc;

  logic [WDW-1:0] got_q[$];
  logic           wr_mode;
  logic           cr_mode;
  int             n_checks;
  int             n_fail;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Forget everything the receiver is allowed to lose on reset.
  task automatic modelReset();
    m_fifo.delete();
    m_lanes.delete();
    m_cmd_pend = 1'b0;
    m_cmd_dat  = '0;
    m_err      = 1'b0;
    m_run      = 1'b0;
    last_acc   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic modelStep();
    logic   m_rdy, acc, pop_e, push_e;
    mword_t w;
    m_rdy  = m_run && (m_fifo.size() < DEPTH) && !m_cmd_pend;
    acc    = chip_dat_vld && m_rdy;
    pop_e  = (m_fifo.size() > 0) && word_rdy;
    push_e = 1'b0;
    w.dat  = '0;
    w.lst  = 1'b0;
    w.cnt  = 0;
    m_err  = acc && chip_dat_cmd && (m_lanes.size() != 0);
    if (m_cmd_pend && cmd_rdy) m_cmd_pend = 1'b0;
    if (acc && chip_dat_cmd) begin
      m_cmd_pend = 1'b1;
      m_cmd_dat  = chip_dat_dat;
    end else if (acc) begin
      m_lanes.push_back(chip_dat_dat);
      if (m_lanes.size() == PACK || chip_dat_lst) begin
        foreach (m_lanes[i]) w.dat = w.dat | (WDW'(m_lanes[i]) << (DW * i));
        w.cnt  = m_lanes.size();
        w.lst  = chip_dat_lst;
        push_e = 1'b1;
        m_lanes.delete();
      end
    end
    if (pop_e) void'(m_fifo.pop_front());
    if (push_e) m_fifo.push_back(w);
    m_run    = 1'b1;
    last_acc = acc;
  endtask

  // Compare every DUT output against what the model says should be visible now.
  task automatic compareAll();
    logic m_rdy;
    m_rdy = m_run && (m_fifo.size() < DEPTH) && !m_cmd_pend;
    checkOutput("chip_dat_rdy", chip_dat_rdy, m_rdy);
    checkOutput("word_vld", word_vld, m_fifo.size() > 0);
    checkOutput("cmd_vld", cmd_vld, m_cmd_pend);
    checkOutput("err_cmd_mid", err_cmd_mid, m_err);
    if (m_fifo.size() > 0) begin
      checkOutput("word_dat", word_dat, m_fifo[0].dat);
      checkOutput("word_lst", word_lst, m_fifo[0].lst);
      checkOutput("word_cnt", word_cnt, m_fifo[0].cnt);
    end
    if (m_cmd_pend) checkOutput("cmd_dat", cmd_dat, m_cmd_dat);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check the outputs.
  task automatic applyStimulus(input logic vld, input logic lst, input logic [DW-1:0] dat,
                               input logic cmd, input logic wrdy, input logic crdy);
    if (word_vld && wrdy) got_q.push_back(word_dat);
    chip_dat_vld = vld;
    chip_dat_lst = lst;
    chip_dat_dat = dat;
    chip_dat_cmd = cmd;
    word_rdy     = wrdy;
    cmd_rdy      = crdy;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  // Hold a beat on the bus until it is taken, giving up after a bounded wait.
  task automatic sendBeat(input logic lst, input logic [DW-1:0] dat, input logic cmd);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      applyStimulus(1'b1, lst, dat, cmd, wr_mode, cr_mode);
      done = last_acc;
    end
    if (!done) checkOutput("send_timeout", 1'b0, 1'b1);
  endtask

  // Idle cycles with the sinks ready so queued words and commands drain.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, then release on a falling edge.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    chip_dat_vld = 1'b0;
    chip_dat_lst = 1'b0;
    chip_dat_dat = '0;
    chip_dat_cmd = 1'b0;
    word_rdy     = 1'b0;
    cmd_rdy      = 1'b0;
    #2;
    modelReset();
    checkOutput({tag, "_rdy"}, chip_dat_rdy, 1'b0);
    checkOutput({tag, "_word_vld"}, word_vld, 1'b0);
    checkOutput({tag, "_word_dat"}, word_dat, '0);
    checkOutput({tag, "_word_lst"}, word_lst, 1'b0);
    checkOutput({tag, "_word_cnt"}, word_cnt, '0);
    checkOutput({tag, "_cmd_vld"}, cmd_vld, 1'b0);
    checkOutput({tag, "_cmd_dat"}, cmd_dat, '0);
    checkOutput({tag, "_err"}, err_cmd_mid, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Hard stop in case something wedges the stimulus loop.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios first, then randomized traffic.
  initial begin
    int k;
    n_checks = 0;
    n_fail   = 0;
    wr_mode  = 1'b1;
    cr_mode  = 1'b1;
    rst_n    = 1'b1;
    got_q.delete();
    modelReset();
    #1;
    doReset("reset");

    // Full word with lst on the fourth beat.
    wr_mode = 1'b0;
    sendBeat(1'b0, 8'h11, 1'b0);
    sendBeat(1'b0, 8'h22, 1'b0);
    sendBeat(1'b0, 8'h33, 1'b0);
    sendBeat(1'b1, 8'h44, 1'b0);
    checkOutput("full_vld", word_vld, 1'b1);
    checkOutput("full_dat", word_dat, 32'h44332211);
    checkOutput("full_lst", word_lst, 1'b1);
    checkOutput("full_cnt", word_cnt, 3'd4);
    drain(3);

    // Six-beat packet: one full word and a two-beat tail.
    got_q.delete();
    wr_mode = 1'b1;
    for (int i = 1; i <= 6; i++) sendBeat(i == 6, 8'(i), 1'b0);
    drain(4);
    checkOutput("tail_count", got_q.size(), 2);
    if (got_q.size() > 0) checkOutput("tail_w0", got_q[0], 32'h04030201);
    if (got_q.size() > 1) checkOutput("tail_w1", got_q[1], 32'h00000605);

    // Backpressure: FIFO fills after eight beats, then drains in order.
    got_q.delete();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
      if (last_acc) k++;
    end
    checkOutput("bp_accepted", k, 8);
    checkOutput("bp_rdy_low", chip_dat_rdy, 1'b0);
    for (int c = 0; c < 40 && k < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 8'(k), 1'b0, 1'b1, 1'b1);
      if (last_acc) k++;
    end
    drain(5);
    checkOutput("bp_count", got_q.size(), 3);
    if (got_q.size() > 0) checkOutput("bp_w0", got_q[0], 32'h03020100);
    if (got_q.size() > 1) checkOutput("bp_w1", got_q[1], 32'h07060504);
    if (got_q.size() > 2) checkOutput("bp_w2", got_q[2], 32'h0B0A0908);

    // Command stall: nothing else gets in until the core takes the command.
    cr_mode = 1'b0;
    sendBeat(1'b0, 8'hA5, 1'b1);
    checkOutput("stall_cmd_vld", cmd_vld, 1'b1);
    checkOutput("stall_cmd_dat", cmd_dat, 8'hA5);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_no_accept", last_acc, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b1);
    checkOutput("stall_released", chip_dat_rdy, 1'b1);
    checkOutput("stall_cmd_clear", cmd_vld, 1'b0);

    // Command landing in the middle of a word.
    wr_mode = 1'b0;
    sendBeat(1'b0, 8'h10, 1'b0);
    sendBeat(1'b0, 8'h20, 1'b0);
    sendBeat(1'b0, 8'h5A, 1'b1);
    checkOutput("mid_err_hi", err_cmd_mid, 1'b1);
    checkOutput("mid_cmd_dat", cmd_dat, 8'h5A);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_err_lo", err_cmd_mid, 1'b0);
    cr_mode = 1'b1;
    sendBeat(1'b0, 8'h30, 1'b0);
    sendBeat(1'b1, 8'h40, 1'b0);
    checkOutput("mid_word_dat", word_dat, 32'h40302010);
    checkOutput("mid_word_cnt", word_cnt, 3'd4);
    checkOutput("mid_word_lst", word_lst, 1'b1);
    drain(3);

    // Reset with a partial word in the packer: no stale lanes afterwards.
    sendBeat(1'b0, 8'h01, 1'b0);
    sendBeat(1'b0, 8'h02, 1'b0);
    doReset("rst_mid");
    sendBeat(1'b0, 8'hAA, 1'b0);
    sendBeat(1'b0, 8'hBB, 1'b0);
    sendBeat(1'b0, 8'hCC, 1'b0);
    sendBeat(1'b1, 8'hDD, 1'b0);
    checkOutput("rst_word_dat", word_dat, 32'hDDCCBBAA);
    drain(3);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    1'($urandom_range(0, 1)));
    end
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip_dat_rx.md
Name: chip_dat_rx

Overview:
Chip-side receiver for the CHIP_DAT pad stream. The host/testbench side drives this stream as the initiator: vld/lst/dat/cmd in, rdy out.
- Accepts narrow beats under a valid/ready handshake.
- Routes command beats (cmd=1) to a single-entry command register.
- Packs data beats LSB-first into WORD_DW-bit words and queues them in a small FIFO for the accelerator core.
- Sits directly behind the input pads inside EEG_TOP.

Parameters:
CHIP_DAT_DW, 8, pad beat width in bits
WORD_DW, 32, internal word width; must be an integer multiple of CHIP_DAT_DW
PACK, WORD_DW/CHIP_DAT_DW (4), beats per word; derived, not overridable
FIFO_DEPTH, 2, output word FIFO depth; power of two, at least 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
chip_dat_vld  in  1  beat valid
chip_dat_lst  in  1  last data beat of a packet (ignored when chip_dat_cmd=1)
chip_dat_dat  in  CHIP_DAT_DW  beat payload
chip_dat_cmd  in  1  beat is a command beat
chip_dat_rdy  out  1  receiver ready
cmd_vld  out  1  command available
cmd_dat  out  CHIP_DAT_DW  command byte
cmd_rdy  in  1  core accepts command
word_vld  out  1  head FIFO word valid
word_dat  out  WORD_DW  packed word
word_lst  out  1  word closes a packet
word_cnt  out  $clog2(PACK)+1  number of valid beats in word (1..PACK)
word_rdy  in  1  core accepts word
err_cmd_mid  out  1  one-cycle pulse: command beat arrived mid-word

Behaviour:
- Clock and reset: single clock domain, clk. rst_n asserts asynchronously (active low) and releases synchronously to clk.
- Reset values: all outputs 0, including chip_dat_rdy. Packer count=0, packer data=0, FIFO empty, command register empty.
- Handshake rules:
  - A beat transfers when chip_dat_vld && chip_dat_rdy at a rising clk.
  - A word transfers on word_vld && word_rdy.
  - A command transfers on cmd_vld && cmd_rdy.
- chip_dat_rdy = !fifo_full && !cmd_vld.
  - Derived from internal state only; no combinational path from any chip_dat_* input.
  - Registered-equivalent timing: it reflects state after the previous edge.
- Packer states: IDLE (cnt=0) and FILL (0<cnt<PACK).
  - An accepted data beat writes chip_dat_dat into bits [cnt*CHIP_DAT_DW +: CHIP_DAT_DW], then cnt increments.
  - Word completes when the accepted beat has cnt==PACK-1 or chip_dat_lst=1.
  - On completion, push {data, lst, cnt+1} to the FIFO in the same edge, return to IDLE, and clear the packer data.
  - Unfilled upper lanes of a partial word are 0.
- Latency: the word completed at edge N has word_vld=1 after edge N, i.e. one cycle after the final beat.
- Command beats:
  - An accepted beat with cmd=1 loads cmd_dat and sets cmd_vld.
  - cmd_vld clears on cmd_rdy; the next command beat is accepted no earlier than the following cycle.
  - A command beat never touches the packer.
  - If cnt!=0 when it is accepted, err_cmd_mid pulses high for exactly one cycle and the partial word is preserved.
- FIFO boundaries:
  - Push is never attempted when full, because rdy already excludes that case.
  - Simultaneous push and pop is legal at any non-full occupancy; occupancy is unchanged.
  - Pop when empty is impossible, since word_vld=0.
  - word_* outputs come straight from the head entry. They hold stable while word_vld && !word_rdy.
- Wrap-around: FIFO read/write pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty distinction.
- Reset mid-operation: the partial word is discarded, queued words and a pending command are dropped, and err_cmd_mid is cleared.
- Arithmetic widths: cnt is $clog2(PACK)+1 bits and never exceeds PACK. word_cnt=PACK for full words.

Decomposition:
- Package eeg_chip_pkg holds:
  - CHIP_DAT_DW, WORD_DW and PACK constants
  - typedef word_ent_t = struct packed {logic lst; logic [$clog2(PACK):0] cnt; logic [WORD_DW-1:0] dat;}
- One sub-module: chip_dat_fifo.
  - Synchronous FIFO of word_ent_t, parameter FIFO_DEPTH.
  - Ports: push/pop/full/empty/head.
- The packer and command register stay in chip_dat_rx.

Test Plan:
- Full word: beats 0x11,0x22,0x33,0x44 with lst on beat 4, word_rdy=1 -> one cycle later word_vld=1, word_dat=0x44332211, word_lst=1, word_cnt=4.
- Partial tail: beats 0x01..0x06 with lst on beat 6 -> word 0x04030201 (lst=0, cnt=4), then 0x00000605 (lst=1, cnt=2).
- Backpressure: word_rdy=0, continuous 12 beats 0x00..0x0B, no lst -> 8 beats accepted, chip_dat_rdy=0 the cycle after beat 8. Then raise word_rdy -> 0x03020100, 0x07060504, 0x0B0A0908 in order, with no loss or duplication.
- Command stall: cmd beat 0xA5 with cmd_rdy=0 -> cmd_vld=1, cmd_dat=0xA5, chip_dat_rdy=0 until the cycle after cmd_rdy=1. Data beats presented meanwhile are not accepted.
- Command mid-word: data 0x10,0x20, then cmd 0x5A, then data 0x30,0x40 (lst) -> err_cmd_mid high exactly one cycle, cmd_dat=0x5A, word 0x40302010 cnt=4 lst=1.
- Reset mid-word: 2 data beats, then assert rst_n=0 for 3 cycles -> all outputs 0 asynchronously. After release, beats 0xAA,0xBB,0xCC,0xDD with lst -> word 0xDDCCBBAA, with no stale lanes.
